// File: rtl/time_keeper_pkg.sv
// Shared constants for the time keeper: field selects, field limits and width,
// plus helpers for per-field limits and write validation.
package time_keeper_pkg;

  localparam int FIELD_W = 8;

  localparam logic [1:0] SEL_SEC = 2'd0;
  localparam logic [1:0] SEL_MIN = 2'd1;
  localparam logic [1:0] SEL_HR  = 2'd2;

  localparam logic [FIELD_W-1:0] SEC_MAX = 8'd59;
  localparam logic [FIELD_W-1:0] MIN_MAX = 8'd59;
  localparam logic [FIELD_W-1:0] HR_MAX  = 8'd23;

  // Field index 0/1/2 lines up with SEL_SEC/SEL_MIN/SEL_HR.
  function automatic logic [FIELD_W-1:0] field_max(input int idx);
    case (idx)
      0:       field_max = SEC_MAX;
      1:       field_max = MIN_MAX;
      default: field_max = HR_MAX;
    endcase
  endfunction

  function automatic logic write_valid(input logic [1:0] sel, input logic [FIELD_W-1:0] val);
    case (sel)
      SEL_SEC: write_valid = (val <= SEC_MAX);
      SEL_MIN: write_valid = (val <= MIN_MAX);
      SEL_HR:  write_valid = (val <= HR_MAX);
      default: write_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/time_keeper_wrap_counter.sv
// Loadable counter that wraps from MAX back to 0 by compare-and-clear.
// Priority: clr > load > inc. carry flags an increment taken at MAX.
module wrap_counter
  import time_keeper_pkg::*;
#(
  parameter logic [FIELD_W-1:0] MAX = 8'd59
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_val,
  output logic [FIELD_W-1:0] count,
  output logic               carry
);

  logic [FIELD_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (inc) begin
      count_reg <= (count_reg == MAX) ? '0 : count_reg + 8'd1;
    end
  end

  assign count = count_reg;
  assign carry = inc && (count_reg == MAX);

endmodule

// File: rtl/time_keeper.sv
// Hours/minutes/seconds keeper with field write/readback and a tick that is
// deferred by one cycle when it collides with a write.
module time_keeper
  import time_keeper_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_reset,
  input  logic               i_wr,
  input  logic [1:0]         i_sel,
  input  logic [FIELD_W-1:0] i_val,
  output logic [FIELD_W-1:0] o_out,
  output logic [FIELD_W-1:0] o_sec,
  output logic [FIELD_W-1:0] o_min,
  output logic [FIELD_W-1:0] o_hr,
  output logic               o_day,
  output logic               o_wr_err
);

  logic               pending_reg, pending_next;
  logic               day_reg, wr_err_reg;
  logic [FIELD_W-1:0] out_reg, out_next;
  logic               wr_ok, advance;

  logic [FIELD_W-1:0] count [3];
  logic               carry [3];
  logic               inc   [3];
  logic               load  [3];

  assign wr_ok   = write_valid(i_sel, i_val);
  assign advance = !i_reset && !i_wr && (i_tick || pending_reg);

  // Seconds feed minutes feed hours through the carry chain.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_field
      localparam logic [FIELD_W-1:0] LIM = field_max(gi);
      assign load[gi] = !i_reset && i_wr && wr_ok && (i_sel == 2'(gi));
      if (gi == 0) begin : g_first
        assign inc[gi] = advance;
      end else begin : g_chain
        assign inc[gi] = carry[gi-1];
      end
      wrap_counter #(.MAX(LIM)) u_cnt (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .clr      (i_reset),
        .inc      (inc[gi]),
        .load     (load[gi]),
        .load_val (i_val),
        .count    (count[gi]),
        .carry    (carry[gi])
      );
    end
  endgenerate

  // A write steals the cycle; remember any tick (new or already pending).
  always_comb begin
    pending_next = 1'b0;
    if (!i_reset && i_wr) begin
      pending_next = pending_reg || i_tick;
    end
  end

  always_comb begin
    out_next = '0;
    case (i_sel)
      SEL_SEC: out_next = count[0];
      SEL_MIN: out_next = count[1];
      SEL_HR:  out_next = count[2];
      default: out_next = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_reg <= 1'b0;
      day_reg     <= 1'b0;
      wr_err_reg  <= 1'b0;
      out_reg     <= '0;
    end else begin
      pending_reg <= pending_next;
      day_reg     <= carry[2];
      wr_err_reg  <= !i_reset && i_wr && !wr_ok;
      out_reg     <= out_next;
    end
  end

  assign o_sec    = count[0];
  assign o_min    = count[1];
  assign o_hr     = count[2];
  assign o_out    = out_reg;
  assign o_day    = day_reg;
  assign o_wr_err = wr_err_reg;

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper: reset, write/readback,
// rollover, rejected writes and tick/write/reset coincidence.
module tb_time_keeper;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_tick, i_reset, i_wr;
  logic [1:0] i_sel;
  logic [7:0] i_val;
  logic [7:0] o_out, o_sec, o_min, o_hr;
  logic       o_day, o_wr_err;

  int n_checks = 0;
  int n_fail   = 0;

  time_keeper dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_tick   (i_tick),
    .i_reset  (i_reset),
    .i_wr     (i_wr),
    .i_sel    (i_sel),
    .i_val    (i_val),
    .o_out    (o_out),
    .o_sec    (o_sec),
    .o_min    (o_min),
    .o_hr     (o_hr),
    .o_day    (o_day),
    .o_wr_err (o_wr_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
    check({tag, ".hr"}, o_hr, h);
    check({tag, ".min"}, o_min, m);
    check({tag, ".sec"}, o_sec, s);
  endtask

  // Drive one cycle of stimulus from a falling edge; strobes drop afterwards, sel holds.
  task automatic cyc(input logic tick, input logic wr, input logic [1:0] sel,
                     input logic [7:0] val, input logic rst);
    i_tick  = tick;
    i_wr    = wr;
    i_sel   = sel;
    i_val   = val;
    i_reset = rst;
    @(negedge i_clk);
    i_tick  = 1'b0;
    i_wr    = 1'b0;
    i_reset = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_tick = 1'b0; i_reset = 1'b0; i_wr = 1'b0; i_sel = 2'd0; i_val = 8'd0;
    repeat (2) @(negedge i_clk);
    check_time("reset", 8'd0, 8'd0, 8'd0);
    check("reset.out", o_out, 8'd0);
    check("reset.day", {7'd0, o_day}, 8'd0);
    check("reset.err", {7'd0, o_wr_err}, 8'd0);
    i_rst_n = 1'b1;

    // Count up, then assert async reset mid-cycle with a pending tick in flight.
    repeat (5) cyc(1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
    check_time("count5", 8'd0, 8'd0, 8'd5);
    cyc(1'b1, 1'b1, 2'd1, 8'd3, 1'b0);
    check("out_before_areset", o_out, 8'd0);
    #2 i_rst_n = 1'b0;
    #1;
    check_time("areset", 8'd0, 8'd0, 8'd0);
    check("areset.out", o_out, 8'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    check_time("post_areset_idle", 8'd0, 8'd0, 8'd0);

    // Write/readback.
    cyc(1'b0, 1'b1, 2'd1, 8'd12, 1'b0);
    check("wr_min", o_min, 8'd12);
    cyc(1'b0, 1'b1, 2'd0, 8'h37, 1'b0);
    check("wr_sec", o_sec, 8'd55);
    check("wr_sec.out_lag", o_out, 8'd0);
    cyc(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    check("wr_sec.out", o_out, 8'd55);
    cyc(1'b0, 1'b0, 2'd1, 8'd0, 1'b0);
    check("rd_min.out", o_out, 8'd12);
    cyc(1'b0, 1'b0, 2'd2, 8'd0, 1'b0);
    check("rd_hr.out", o_out, 8'd0);

    // Seconds carry into minutes without a day pulse.
    cyc(1'b0, 1'b1, 2'd0, 8'd59, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
    check_time("sec_carry", 8'd0, 8'd13, 8'd0);
    check("sec_carry.day", {7'd0, o_day}, 8'd0);

    // Full rollover.
    cyc(1'b0, 1'b1, 2'd2, 8'd23, 1'b0);
    cyc(1'b0, 1'b1, 2'd1, 8'd59, 1'b0);
    cyc(1'b0, 1'b1, 2'd0, 8'd59, 1'b0);
    check_time("pre_roll", 8'd23, 8'd59, 8'd59);
    check("pre_roll.day", {7'd0, o_day}, 8'd0);
    cyc(1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
    check_time("roll", 8'd0, 8'd0, 8'd0);
    check("roll.day", {7'd0, o_day}, 8'd1);
    cyc(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    check("roll.day_drop", {7'd0, o_day}, 8'd0);

    // Rejected writes leave 00:00:07 untouched.
    cyc(1'b0, 1'b1, 2'd0, 8'd7, 1'b0);
    cyc(1'b0, 1'b1, 2'd2, 8'd24, 1'b0);
    check_time("rej_hr24", 8'd0, 8'd0, 8'd7);
    check("rej_hr24.err", {7'd0, o_wr_err}, 8'd1);
    cyc(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    check("rej_hr24.err_drop", {7'd0, o_wr_err}, 8'd0);
    cyc(1'b0, 1'b1, 2'd0, 8'd60, 1'b0);
    check_time("rej_sec60", 8'd0, 8'd0, 8'd7);
    check("rej_sec60.err", {7'd0, o_wr_err}, 8'd1);
    cyc(1'b0, 1'b1, 2'd3, 8'd5, 1'b0);
    check_time("rej_sel3", 8'd0, 8'd0, 8'd7);
    check("rej_sel3.err", {7'd0, o_wr_err}, 8'd1);
    cyc(1'b0, 1'b0, 2'd3, 8'd0, 1'b0);
    check("rej_sel3.err_drop", {7'd0, o_wr_err}, 8'd0);
    check("sel3.out", o_out, 8'd0);

    // Tick/write coincidence from 00:00:05.
    cyc(1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
    check_time("soft_clr", 8'd0, 8'd0, 8'd0);
    repeat (5) cyc(1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
    cyc(1'b1, 1'b1, 2'd1, 8'd10, 1'b0);
    check_time("coin_wr", 8'd0, 8'd10, 8'd5);
    cyc(1'b0, 1'b0, 2'd1, 8'd0, 1'b0);
    check_time("coin_pend", 8'd0, 8'd10, 8'd6);
    cyc(1'b0, 1'b0, 2'd1, 8'd0, 1'b0);
    check_time("coin_idle", 8'd0, 8'd10, 8'd6);

    // Pending tick plus a fresh tick advances exactly one step.
    cyc(1'b1, 1'b1, 2'd1, 8'd11, 1'b0);
    cyc(1'b1, 1'b0, 2'd1, 8'd0, 1'b0);
    check_time("pend_plus_tick", 8'd0, 8'd11, 8'd7);
    cyc(1'b0, 1'b0, 2'd1, 8'd0, 1'b0);
    check_time("pend_plus_tick_idle", 8'd0, 8'd11, 8'd7);

    // Invalid write still defers the tick.
    cyc(1'b1, 1'b1, 2'd3, 8'd0, 1'b0);
    check_time("coin_bad_wr", 8'd0, 8'd11, 8'd7);
    check("coin_bad_wr.err", {7'd0, o_wr_err}, 8'd1);
    cyc(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    check_time("coin_bad_pend", 8'd0, 8'd11, 8'd8);

    // Soft clear beats write and tick, and drops a pending tick.
    cyc(1'b1, 1'b1, 2'd1, 8'd20, 1'b0);
    cyc(1'b1, 1'b1, 2'd1, 8'd30, 1'b1);
    check_time("coin_reset", 8'd0, 8'd0, 8'd0);
    check("coin_reset.err", {7'd0, o_wr_err}, 8'd0);
    cyc(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    check_time("coin_reset_idle", 8'd0, 8'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
